muldiv_seq: RTL
===============

MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL: CLK  in  1  single clock; every state element updates on the rising edge.
REQ-002 SHALL: RESET  in  1  reset, synchronous and active-high.
REQ-003 SHALL: Start_IN  in  1  request to begin a multiply or divide.
REQ-004 SHALL: Op_IN  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 SHALL: OperandA_IN  in  32  multiplicand or dividend, already forwarded.
REQ-006 SHALL: OperandB_IN  in  32  multiplier or divisor, already forwarded.
REQ-007 SHALL: WriteHI_IN / WriteLO_IN  in  1 each  MTHI / MTLO request.
REQ-008 SHALL: MoveData_IN  in  32  data written by MTHI / MTLO.
REQ-009 SHALL: HiLoRead_IN  in  1  an MFHI or MFLO is in EXE this cycle.
REQ-010 SHALL: Flush_IN  in  1  abort any in-flight operation.
REQ-011 SHALL: HI_OUT / LO_OUT  out  32 each  architectural HI and LO registers.
REQ-012 SHALL: Busy_OUT  out  1  operation in flight.
REQ-013 SHALL: Stall_OUT  out  1  combinational; holds the IF, ID and EXE stages.
REQ-014 SHALL: Done_OUT  out  1  one-cycle pulse when a result is committed.
REQ-015 SHALL: DivByZero_OUT  out  1  pulses together with Done_OUT for a divide by zero.

Function
REQ-016 SHALL: FSM states are IDLE, RUN and FIX; Busy_OUT = (state != IDLE).
REQ-017 SHALL: In IDLE, Start_IN=1 with Flush_IN=0 at edge E0 latches Op_IN, the operand magnitudes (signed ops) or raw operands (unsigned ops) and both operand signs, sets iteration count to 31, and moves to RUN.
REQ-018 SHALL: RUN performs one radix-2 step per cycle, either shift-add (multiply) or restoring shift-subtract (divide), with 64-bit accumulator width.
REQ-019 SHALL: RUN moves to FIX after 32 steps, at edge E32.
REQ-020 SHALL: FIX applies sign correction.
  - Multiply: 64-bit product negated if signA^signB.
  - Divide: quotient negated if signA^signB; remainder negated if signA.
REQ-021 SHALL: At edge E33, FIX writes HI (product[63:32] or remainder) and LO (product[31:0] or quotient), sets Done_OUT=1 for exactly one cycle, and returns to IDLE.
REQ-022 SHALL: Latency from accept edge to result visible on HI_OUT/LO_OUT is 33 cycles for every operation.
REQ-023 SHALL: DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
REQ-024 SHALL: A divide by zero runs the full latency, gives HI=dividend, LO=0xFFFFFFFF, and pulses DivByZero_OUT.
REQ-025 SHALL: Stall_OUT = Busy_OUT & (Start_IN | HiLoRead_IN | WriteHI_IN | WriteLO_IN); while busy, those requests are held, never dropped, and never accepted.
REQ-026 SHALL: In IDLE, WriteHI_IN / WriteLO_IN write MoveData_IN at the next edge; simultaneous WriteHI_IN and WriteLO_IN write both registers.
REQ-027 SHALL: When Start_IN and WriteHI_IN/WriteLO_IN coincide in IDLE, the move applies at E0 and the operation result overwrites it at E33.
REQ-028 SHALL: Flush_IN=1 in RUN or FIX returns to IDLE at the next edge, leaves HI/LO unchanged, and produces no Done_OUT.
REQ-029 SHALL: Flush_IN=1 in IDLE suppresses Start_IN and all moves that cycle.
REQ-030 SHALL: The block never writes HI/LO except through REQ-021 and REQ-026.

Reset
REQ-031 SHALL: RESET=1 at an edge forces state=IDLE, HI_OUT=0, LO_OUT=0, Done_OUT=0, DivByZero_OUT=0, count=0 and accumulators=0, with priority over Start, moves and Flush.
REQ-032 SHALL: RESET mid-operation discards the operation with no Done_OUT; Busy_OUT=0 in the cycle after the reset edge.

Structure
REQ-033 SHALL: A shared package muldiv_pkg holds the Op encodings, FSM state encoding, MD_ITER=32 and DIV0_LO=32'hFFFFFFFF.
REQ-034 SHALL: One sub-module, muldiv_step, is combinational and computes a single shift-add or shift-subtract step from the accumulator, operand and op kind; muldiv_seq owns all registers and the FSM.

Verification
REQ-035 SHALL: MULT A=0xFFFFFFFE, B=3 -> after 33 cycles HI=0xFFFFFFFF, LO=0xFFFFFFFA, Done_OUT high for 1 cycle.
REQ-036 SHALL: MULTU A=0xFFFFFFFE, B=3 -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-037 SHALL: DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/0 -> HI=7, LO=0xFFFFFFFF, DivByZero_OUT pulse.
REQ-038 SHALL: HiLoRead_IN held high from cycle 2 after Start -> Stall_OUT=1 through cycle 33, low in the Done_OUT cycle, HI_OUT already new.
REQ-039 SHALL: Preload HI=0x11, LO=0x22, then Start MULT, then Flush_IN at cycle 10 -> Busy_OUT=0 at cycle 11, HI/LO stay 0x11/0x22, no Done_OUT.
REQ-040 SHALL: RESET at cycle 20 of a DIV -> all outputs 0 the next cycle; a fresh MULTU 5*6 then gives LO=30, HI=0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the sequential multiply/divide unit.
// Op encodings, FSM states and iteration/result constants.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10
    } state_e;

    localparam int unsigned MD_ITER = 32;
    localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

    function automatic logic op_is_div(input op_e op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input op_e op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the EXE stage and the mul/div unit.
// master drives requests, slave returns HI/LO and status.
interface muldiv_if;
    logic        Start_IN;
    logic [1:0]  Op_IN;
    logic [31:0] OperandA_IN;
    logic [31:0] OperandB_IN;
    logic        WriteHI_IN;
    logic        WriteLO_IN;
    logic [31:0] MoveData_IN;
    logic        HiLoRead_IN;
    logic        Flush_IN;
    logic [31:0] HI_OUT;
    logic [31:0] LO_OUT;
    logic        Busy_OUT;
    logic        Stall_OUT;
    logic        Done_OUT;
    logic        DivByZero_OUT;

    modport master (
        output Start_IN, Op_IN, OperandA_IN, OperandB_IN,
        output WriteHI_IN, WriteLO_IN, MoveData_IN,
        output HiLoRead_IN, Flush_IN,
        input  HI_OUT, LO_OUT, Busy_OUT, Stall_OUT,
        input  Done_OUT, DivByZero_OUT
    );

    modport slave (
        input  Start_IN, Op_IN, OperandA_IN, OperandB_IN,
        input  WriteHI_IN, WriteLO_IN, MoveData_IN,
        input  HiLoRead_IN, Flush_IN,
        output HI_OUT, LO_OUT, Busy_OUT, Stall_OUT,
        output Done_OUT, DivByZero_OUT
    );
endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide.
// Accumulator is {hi, lo}; lo holds multiplier or dividend bits.
module muldiv_step (
    input  logic [63:0] acc_i,
    input  logic [31:0] opnd_i,
    input  logic        div_i,
    output logic [63:0] acc_o
);

    logic [32:0] mul_sum;
    logic [32:0] rem_sh;
    logic        ge;
    logic [31:0] diff;

    // Compute both step kinds and select by op kind.
    always_comb begin
        mul_sum = {1'b0, acc_i[63:32]}
                + (acc_i[0] ? {1'b0, opnd_i} : 33'd0);
        rem_sh  = acc_i[63:31];
        ge      = (rem_sh >= {1'b0, opnd_i});
        diff    = rem_sh[31:0] - opnd_i;
        if (div_i) begin
            if (ge) begin
                acc_o = {diff, acc_i[30:0], 1'b1};
            end else begin
                acc_o = {rem_sh[31:0], acc_i[30:0], 1'b0};
            end
        end else begin
            acc_o = {mul_sum, acc_i[31:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential 32-cycle multiply/divide unit with HI/LO registers.
// Fixed 33-cycle latency, flushable, stalls dependent requests.
module muldiv_seq
    import muldiv_pkg::*;
(
    input  logic    CLK,
    input  logic    RESET,
    muldiv_if.slave bus
);

    state_e      state_q;
    op_e         op_q;
    logic [4:0]  count_q;
    logic [63:0] acc_q;
    logic [63:0] acc_d;
    logic [31:0] opnd_q;
    logic        sign_a_q;
    logic        sign_b_q;
    logic        dbz_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        done_q;
    logic        dbz_out_q;

    op_e         op_in;
    logic        sgn_in;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic        run_div;
    logic [63:0] prod;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] fix_hi_d;
    logic [31:0] fix_lo_d;

    assign run_div = op_is_div(op_q);

    muldiv_step u_step (
        .acc_i  (acc_q),
        .opnd_i (opnd_q),
        .div_i  (run_div),
        .acc_o  (acc_d)
    );

    // Operand magnitudes for signed ops, raw operands otherwise.
    always_comb begin
        op_in  = op_e'(bus.Op_IN);
        sgn_in = op_is_signed(op_in);
        mag_a  = (sgn_in && bus.OperandA_IN[31])
               ? (~bus.OperandA_IN + 32'd1) : bus.OperandA_IN;
        mag_b  = (sgn_in && bus.OperandB_IN[31])
               ? (~bus.OperandB_IN + 32'd1) : bus.OperandB_IN;
    end

    // Sign correction of the raw magnitude result in FIX.
    always_comb begin
        prod = acc_q;
        quo  = acc_q[31:0];
        rem  = acc_q[63:32];
        if (op_is_signed(op_q)) begin
            if (sign_a_q ^ sign_b_q) begin
                prod = ~acc_q + 64'd1;
                quo  = ~acc_q[31:0] + 32'd1;
            end
            if (sign_a_q) begin
                rem = ~acc_q[63:32] + 32'd1;
            end
        end
        if (dbz_q) begin
            quo = DIV0_LO;
        end
        fix_hi_d = run_div ? rem : prod[63:32];
        fix_lo_d = run_div ? quo : prod[31:0];
    end

    // Control FSM, iteration datapath and HI/LO registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            op_q      <= OP_MULT;
            count_q   <= 5'd0;
            acc_q     <= 64'd0;
            opnd_q    <= 32'd0;
            sign_a_q  <= 1'b0;
            sign_b_q  <= 1'b0;
            dbz_q     <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            done_q    <= 1'b0;
            dbz_out_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            dbz_out_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (!bus.Flush_IN) begin
                        if (bus.WriteHI_IN) begin
                            hi_q <= bus.MoveData_IN;
                        end
                        if (bus.WriteLO_IN) begin
                            lo_q <= bus.MoveData_IN;
                        end
                        if (bus.Start_IN) begin
                            op_q     <= op_in;
                            sign_a_q <= bus.OperandA_IN[31];
                            sign_b_q <= bus.OperandB_IN[31];
                            dbz_q    <= op_is_div(op_in)
                                     && (bus.OperandB_IN == 32'd0);
                            count_q  <= 5'(MD_ITER - 1);
                            if (op_is_div(op_in)) begin
                                acc_q  <= {32'd0, mag_a};
                                opnd_q <= mag_b;
                            end else begin
                                acc_q  <= {32'd0, mag_b};
                                opnd_q <= mag_a;
                            end
                            state_q <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (bus.Flush_IN) begin
                        state_q <= S_IDLE;
                    end else begin
                        acc_q   <= acc_d;
                        count_q <= count_q - 5'd1;
                        if (count_q == 5'd0) begin
                            state_q <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    if (bus.Flush_IN) begin
                        state_q <= S_IDLE;
                    end else begin
                        hi_q      <= fix_hi_d;
                        lo_q      <= fix_lo_d;
                        done_q    <= 1'b1;
                        dbz_out_q <= dbz_q;
                        state_q   <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.HI_OUT        = hi_q;
    assign bus.LO_OUT        = lo_q;
    assign bus.Busy_OUT      = (state_q != S_IDLE);
    assign bus.Done_OUT      = done_q;
    assign bus.DivByZero_OUT = dbz_out_q;
    assign bus.Stall_OUT     = bus.Busy_OUT
                             & (bus.Start_IN | bus.HiLoRead_IN
                             | bus.WriteHI_IN | bus.WriteLO_IN);

endmodule
